// File: rtl/reg_file.sv
// rtl/reg_file.sv - register bank with one write port and two registered read ports
// Write-first bypass on both read ports; optional hardwired-zero entry 0.
module reg_file #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // Per-entry load enable; entry 0 never loads when it is hardwired to zero.
  always_comb begin
    load = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i] = we && (waddr == AW'(i)) && !(ZERO_R0 && (i == 0));
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          entry[g] <= '0;
        end else if (load[g]) begin
          entry[g] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    next_a = (we && (waddr == raddr_a)) ? wdata : entry[raddr_a];
    next_b = (we && (waddr == raddr_b)) ? wdata : entry[raddr_b];
    if (ZERO_R0 && (raddr_a == '0)) next_a = '0;
    if (ZERO_R0 && (raddr_b == '0)) next_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= next_a;
      rdata_b <= next_b;
    end
  end

endmodule
